// File: rtl/pmu_pkg.sv
// Shared types and default timing for the two-domain power sequencer.
// Output decode is a pure function of FSM state so both domains stay identical.
package pmu_pkg;

    typedef enum logic [3:0] {
        ST_ON,
        ST_ISO,
        ST_SAVE,
        ST_OFF_WAIT,
        ST_OFF,
        ST_ON_WAIT,
        ST_SETTLE,
        ST_RESTORE,
        ST_DEISO
    } pmu_state_t;

    localparam int         ISO_CYCLES_DEF    = 2;
    localparam int         SETTLE_CYCLES_DEF = 8;
    localparam int         TIMEOUT_DEF       = 64;
    localparam logic [1:0] RET_MASK_DEF      = 2'b01;

    typedef struct packed {
        logic pwr_en;
        logic iso_en;
        logic save;
        logic restore;
        logic dom_on;
    } dom_out_t;

    localparam dom_out_t OUTS_RST = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0,
                                      restore: 1'b0, dom_on: 1'b1};

    function automatic dom_out_t state_outs(pmu_state_t st);
        dom_out_t o;
        o.pwr_en  = !(st == ST_OFF_WAIT || st == ST_OFF);
        o.iso_en  = !(st == ST_ON || st == ST_DEISO);
        o.save    = (st == ST_SAVE);
        o.restore = (st == ST_RESTORE);
        o.dom_on  = (st == ST_ON);
        return o;
    endfunction

endpackage

// File: rtl/pmu_dom_fsm.sv
// Per-domain sleep/wake sequencer; leaves ON/OFF the cycle after grant, outputs registered.
// No backpressure: a granted sequence always runs to completion, ack timeouts just flag tmo.
module pmu_dom_fsm
    import pmu_pkg::*;
#(
    parameter int ISO_CYCLES    = ISO_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF,
    parameter bit RET           = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       pwr_ack,
    input  logic       grant,
    input  logic       tmr_zero,
    output logic       eligible,
    output logic       release_o,
    output logic       tmr_ld,
    output logic [7:0] tmr_val,
    output logic       tmo,
    output logic       pwr_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       dom_on,
    output logic       done
);

    // Timer counts down to zero inclusive, so load N-1 for an N-cycle dwell.
    localparam logic [7:0] ISO_LD    = 8'(ISO_CYCLES - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TMO_LD    = 8'(TIMEOUT - 1);

    pmu_state_t state_q, state_d;
    dom_out_t   outs_q, outs_d;
    logic       done_q, done_d;

    always_comb begin
        state_d   = state_q;
        tmr_ld    = 1'b0;
        tmr_val   = 8'd0;
        tmo       = 1'b0;
        release_o = 1'b0;
        case (state_q)
            ST_ON: if (grant) begin
                state_d = ST_ISO;
                tmr_ld  = 1'b1;
                tmr_val = ISO_LD;
            end
            ST_ISO: if (tmr_zero) begin
                if (RET) begin
                    state_d = ST_SAVE;
                end else begin
                    state_d = ST_OFF_WAIT;
                    tmr_ld  = 1'b1;
                    tmr_val = TMO_LD;
                end
            end
            ST_SAVE: begin
                state_d = ST_OFF_WAIT;
                tmr_ld  = 1'b1;
                tmr_val = TMO_LD;
            end
            ST_OFF_WAIT: if (!pwr_ack || tmr_zero) begin
                state_d   = ST_OFF;
                tmo       = pwr_ack;
                release_o = 1'b1;
            end
            ST_OFF: if (grant) begin
                state_d = ST_ON_WAIT;
                tmr_ld  = 1'b1;
                tmr_val = TMO_LD;
            end
            ST_ON_WAIT: if (pwr_ack || tmr_zero) begin
                state_d = ST_SETTLE;
                tmo     = !pwr_ack;
                tmr_ld  = 1'b1;
                tmr_val = SETTLE_LD;
            end
            ST_SETTLE: if (tmr_zero) begin
                state_d = RET ? ST_RESTORE : ST_DEISO;
            end
            ST_RESTORE: state_d = ST_DEISO;
            ST_DEISO: begin
                state_d   = ST_ON;
                release_o = 1'b1;
            end
            default: state_d = ST_ON;
        endcase
        eligible = (state_q == ST_ON && sleep_req) || (state_q == ST_OFF && wake_req);
        outs_d   = state_outs(state_d);
        done_d   = release_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ON;
            outs_q  <= OUTS_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            done_q  <= done_d;
        end
    end

    assign pwr_en  = outs_q.pwr_en;
    assign iso_en  = outs_q.iso_en;
    assign save    = outs_q.save;
    assign restore = outs_q.restore;
    assign dom_on  = outs_q.dom_on;
    assign done    = done_q;

endmodule

// File: rtl/pmu_seq.sv
// Two-domain power sequencer: round-robin token arbiter, shared dwell timer, sticky ack-timeout flags.
// Grant registered one cycle after an eligible request; no backpressure, losers wait for the token.
module pmu_seq
    import pmu_pkg::*;
#(
    parameter int         ISO_CYCLES    = ISO_CYCLES_DEF,
    parameter int         SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int         TIMEOUT       = TIMEOUT_DEF,
    parameter logic [1:0] RET_MASK      = RET_MASK_DEF
) (
    input  logic       clk_fast,
    input  logic       rst_n,
    input  logic [1:0] sleep_req,
    input  logic [1:0] wake_req,
    input  logic [1:0] pwr_ack,
    output logic [1:0] pwr_en,
    output logic [1:0] iso_en,
    output logic [1:0] save,
    output logic [1:0] restore,
    output logic [1:0] dom_on,
    output logic [1:0] done,
    output logic       busy,
    output logic [1:0] err
);

    logic [1:0]      elig, rel, tmr_ld, tmo;
    logic [1:0][7:0] tmr_val;
    logic            tmr_zero;
    logic            pick;

    logic            tok_vld_q, tok_vld_d;
    logic            pri_q, pri_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [7:0]      tmr_q, tmr_d;
    logic [1:0]      err_q, err_d;

    for (genvar g = 0; g < 2; g++) begin : g_dom
        pmu_dom_fsm #(
            .ISO_CYCLES    (ISO_CYCLES),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .TIMEOUT       (TIMEOUT),
            .RET           (RET_MASK[g])
        ) u_fsm (
            .clk       (clk_fast),
            .rst_n     (rst_n),
            .sleep_req (sleep_req[g]),
            .wake_req  (wake_req[g]),
            .pwr_ack   (pwr_ack[g]),
            .grant     (gnt_q[g]),
            .tmr_zero  (tmr_zero),
            .eligible  (elig[g]),
            .release_o (rel[g]),
            .tmr_ld    (tmr_ld[g]),
            .tmr_val   (tmr_val[g]),
            .tmo       (tmo[g]),
            .pwr_en    (pwr_en[g]),
            .iso_en    (iso_en[g]),
            .save      (save[g]),
            .restore   (restore[g]),
            .dom_on    (dom_on[g]),
            .done      (done[g])
        );
    end

    assign tmr_zero = (tmr_q == 8'd0);

    always_comb begin
        tok_vld_d = tok_vld_q;
        pri_d     = pri_q;
        gnt_d     = 2'b00;
        // pri_q names the domain that wins a tie; it flips away from whoever was just granted.
        pick      = elig[pri_q] ? pri_q : ~pri_q;
        if (tok_vld_q) begin
            if (|rel) tok_vld_d = 1'b0;
        end else if (|elig) begin
            tok_vld_d   = 1'b1;
            gnt_d[pick] = 1'b1;
            pri_d       = ~pick;
        end

        // Only the token holder is ever mid-sequence, so at most one load is active.
        if (tmr_ld[0])         tmr_d = tmr_val[0];
        else if (tmr_ld[1])    tmr_d = tmr_val[1];
        else if (!tmr_zero)    tmr_d = tmr_q - 8'd1;
        else                   tmr_d = tmr_q;

        err_d = err_q | tmo;
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            tok_vld_q <= 1'b0;
            pri_q     <= 1'b0;
            gnt_q     <= 2'b00;
            tmr_q     <= 8'd0;
            err_q     <= 2'b00;
        end else begin
            tok_vld_q <= tok_vld_d;
            pri_q     <= pri_d;
            gnt_q     <= gnt_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
        end
    end

    assign busy = tok_vld_q;
    assign err  = err_q;

endmodule

// File: tb/tb_pmu_seq.sv
// Scoreboard bench for pmu_seq: a transaction-level model predicts grant order and done timing.
module tb_pmu_seq;
    import pmu_pkg::*;

    localparam int         ISO    = 2;
    localparam int         SETTLE = 8;
    localparam int         TMO    = 64;
    localparam logic [1:0] RET    = 2'b01;

    logic       clk_fast = 1'b0;
    logic       rst_n    = 1'b0;
    logic [1:0] sleep_req = 2'b00;
    logic [1:0] wake_req  = 2'b00;
    logic [1:0] pwr_ack   = 2'b11;
    logic [1:0] pwr_en, iso_en, save, restore, dom_on, done, err;
    logic       busy;

    pmu_seq #(
        .ISO_CYCLES    (ISO),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT       (TMO),
        .RET_MASK      (RET)
    ) dut (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .sleep_req (sleep_req),
        .wake_req  (wake_req),
        .pwr_ack   (pwr_ack),
        .pwr_en    (pwr_en),
        .iso_en    (iso_en),
        .save      (save),
        .restore   (restore),
        .dom_on    (dom_on),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk_fast = ~clk_fast;

    int unsigned cyc = 0;
    always @(posedge clk_fast) cyc <= cyc + 1;

    typedef struct {
        int          dom;
        int unsigned cyc;
        logic        on;
        logic [1:0]  err;
        int          sv;
        int          rs;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference model: stable state per domain, tie priority, sticky error flags.
    logic [1:0] m_on  = 2'b11;
    int         m_pri = 0;
    logic [1:0] m_err = 2'b00;

    // Rail model knobs: ack follows pwr_en after dly cycles unless stuck.
    int         dly[2] = '{0, 0};
    logic [1:0] stuck  = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from grant edge to done edge, straight from the sequencing rules.
    function automatic int dur(input int d, input logic slp, input int dl, input logic stk);
        int w;
        int r;
        w = stk ? TMO : ((dl + 1 < TMO) ? dl + 1 : TMO);
        r = RET[d] ? 1 : 0;
        if (slp) return 1 + ISO + r + w;
        return 1 + w + SETTLE + r + 1;
    endfunction

    initial begin
        int cnt[2];
        cnt = '{0, 0};
        forever begin
            @(negedge clk_fast);
            for (int i = 0; i < 2; i++) begin
                if (!stuck[i] && pwr_ack[i] != pwr_en[i]) begin
                    if (cnt[i] >= dly[i]) begin
                        pwr_ack[i] = pwr_en[i];
                        cnt[i]     = 0;
                    end else begin
                        cnt[i]++;
                    end
                end else begin
                    cnt[i] = 0;
                end
            end
        end
    end

    // Monitor: every done pulse pops one expectation.
    initial begin
        int   sv_cnt[2];
        int   rs_cnt[2];
        exp_t e;
        sv_cnt = '{0, 0};
        rs_cnt = '{0, 0};
        forever begin
            @(negedge clk_fast);
            for (int i = 0; i < 2; i++) begin
                if (save[i])    sv_cnt[i]++;
                if (restore[i]) rs_cnt[i]++;
                if (done[i]) begin
                    check("done_expected", (sb.size() != 0) ? 1 : 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("done_dom",    i,         e.dom);
                        check("done_cycle",  cyc,       e.cyc);
                        check("done_dom_on", dom_on[i], e.on);
                        check("done_iso_en", iso_en[i], !e.on);
                        check("done_pwr_en", pwr_en[i], e.on);
                        check("done_err",    err,       e.err);
                        check("done_busy",   busy,      0);
                        check("save_count",  sv_cnt[i], e.sv);
                        check("rest_count",  rs_cnt[i], e.rs);
                    end
                    sv_cnt[i] = 0;
                    rs_cnt[i] = 0;
                end
            end
        end
    end

    task automatic run_txn(input logic [1:0] sl, input logic [1:0] wk,
                           input int d0, input int d1, input logic [1:0] stk);
        logic [1:0]  elig;
        logic [1:0]  pend;
        int          order[$];
        int unsigned t;
        exp_t        e;
        for (int i = 0; i < 2; i++) elig[i] = m_on[i] ? sl[i] : wk[i];
        if (elig == 2'b11) begin
            order.push_back(m_pri);
            order.push_back(1 - m_pri);
        end else begin
            for (int i = 0; i < 2; i++) if (elig[i]) order.push_back(i);
        end
        dly[0] = d0;
        dly[1] = d1;
        stuck  = stk & elig;
        t      = cyc;
        foreach (order[k]) begin
            int   d;
            logic slp;
            d     = order[k];
            slp   = m_on[d];
            t     = t + 1 + dur(d, slp, dly[d], stuck[d]);
            if (stuck[d]) m_err[d] = 1'b1;
            m_on[d] = !slp;
            m_pri   = 1 - d;
            e.dom = d;
            e.cyc = t;
            e.on  = m_on[d];
            e.err = m_err;
            e.sv  = (slp && RET[d]) ? 1 : 0;
            e.rs  = (!slp && RET[d]) ? 1 : 0;
            sb.push_back(e);
        end
        sleep_req = sl;
        wake_req  = wk;
        pend      = elig;
        for (int c = 0; c < 600 && pend != 2'b00; c++) begin
            @(negedge clk_fast);
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    sleep_req[i] = 1'b0;
                    wake_req[i]  = 1'b0;
                    stuck[i]     = 1'b0;
                    pend[i]      = 1'b0;
                end
            end
        end
        check("txn_complete", pend, 2'b00);
        repeat (4) @(negedge clk_fast);
        sleep_req = 2'b00;
        wake_req  = 2'b00;
        stuck     = 2'b00;
        repeat (12) @(negedge clk_fast);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_fast);
        check("rst_pwr_en", pwr_en, 2'b11);
        check("rst_iso_en", iso_en, 2'b00);
        check("rst_dom_on", dom_on, 2'b11);
        check("rst_busy",   busy,   0);
        check("rst_err",    err,    2'b00);
        check("rst_pulses", {save, restore, done}, 6'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_fast);

        run_txn(2'b01, 2'b00, 2, 0, 2'b00);   // sleep d0, ack 2 cycles late
        run_txn(2'b00, 2'b01, 3, 0, 2'b00);   // wake d0, ack 3 cycles late
        run_txn(2'b10, 2'b00, 0, 1, 2'b00);   // sleep d1, no retention
        run_txn(2'b00, 2'b10, 0, 1, 2'b00);
        run_txn(2'b11, 2'b00, 1, 2, 2'b00);   // tie: d0 first
        run_txn(2'b00, 2'b11, 0, 0, 2'b00);
        run_txn(2'b01, 2'b00, 0, 0, 2'b00);
        run_txn(2'b00, 2'b01, 0, 0, 2'b00);
        run_txn(2'b11, 2'b00, 0, 0, 2'b00);   // d0 granted last: d1 first
        run_txn(2'b00, 2'b11, 4, 1, 2'b00);
        run_txn(2'b00, 2'b11, 0, 0, 2'b00);   // wake while ON: ignored
        run_txn(2'b10, 2'b00, 0, 0, 2'b10);   // d1 ack stuck high: timeout
        run_txn(2'b00, 2'b10, 2, 2, 2'b00);

        for (int n = 0; n < 30; n++) begin
            logic [1:0] s;
            logic [1:0] w;
            logic [1:0] k;
            s = 2'($urandom_range(0, 3));
            w = 2'($urandom_range(0, 3));
            k = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(s, w, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), k);
        end

        check("err_sticky", err, m_err);
        check("sb_drained", sb.size(), 0);

        if (m_on[0]) run_txn(2'b01, 2'b00, 0, 0, 2'b00);
        stuck[0]    = 1'b1;
        wake_req[0] = 1'b1;
        repeat (5) @(negedge clk_fast);
        check("on_wait_state", {pwr_en[0], dom_on[0], busy}, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwr_en", pwr_en, 2'b11);
        check("arst_iso_en", iso_en, 2'b00);
        check("arst_dom_on", dom_on, 2'b11);
        check("arst_busy",   busy,   0);
        check("arst_err",    err,    2'b00);
        check("arst_pulses", {save, restore, done}, 6'b0);
        wake_req = 2'b00;
        stuck    = 2'b00;
        @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_fast);
        check("post_rst_idle", {busy, dom_on, err}, 5'b01100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
